// File: rtl/pfa_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : pfa_pkg
//  Purpose   : Shared types and elaboration-time helpers for the pipelined
//              parallel-prefix adder/subtractor (pfa_pipe_param).
//  Revision  : 1.0  initial release
// ============================================================================
package pfa_pkg;

  // Generate/propagate pair carried through the prefix network
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Cycles from accept to out_valid: one input stage plus one stage per
  // group of reg_every prefix levels (the last group may be partial).
  function automatic int pfa_lat(input int width, input int reg_every);
    return 1 + (clog2(width) + reg_every - 1) / reg_every;
  endfunction

endpackage : pfa_pkg
`default_nettype wire

// File: rtl/pfa_pipe_param_if.sv
`default_nettype none
// ============================================================================
//  Interface : pfa_pipe_param_if
//  Purpose   : Operand/result stream bundle for pfa_pipe_param.
//              master = producer/consumer side, slave = arithmetic unit.
//  Config    : PFA_PIPE_FLAGS_EN adds the ovf/zero result flags.
//  Revision  : 1.0  initial release
// ============================================================================
interface pfa_pipe_param_if
  import pfa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             op_sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [TAG_W-1:0] tag_out;
`ifdef PFA_PIPE_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  modport master (
`ifdef PFA_PIPE_FLAGS_EN
    input  ovf, zero,
`endif
    output in_valid, x, y, cin, op_sub, tag_in, out_ready,
    input  in_ready, out_valid, s, cout, tag_out
  );

  modport slave (
`ifdef PFA_PIPE_FLAGS_EN
    output ovf, zero,
`endif
    input  in_valid, x, y, cin, op_sub, tag_in, out_ready,
    output in_ready, out_valid, s, cout, tag_out
  );

endinterface : pfa_pipe_param_if
`default_nettype wire

// File: rtl/pfa_prefix_cell.sv
`default_nettype none
// ============================================================================
//  Module    : pfa_prefix_cell
//  Purpose   : One prefix combine of a high group (gh,ph) with the adjacent
//              low group (gl,pl): G = gh | ph&gl, P = ph&pl.
//  Revision  : 1.0  initial release
// ============================================================================
module pfa_prefix_cell (
  input  wire  gh,
  input  wire  ph,
  input  wire  gl,
  input  wire  pl,
  output logic G,
  output logic P
);

  // Group generate/propagate of the concatenated span
  always_comb begin
    G = gh | (ph & gl);
    P = ph & pl;
  end

endmodule : pfa_prefix_cell
`default_nettype wire

// File: rtl/pfa_pipe_param.sv
`default_nettype none
// ============================================================================
//  Module    : pfa_pipe_param
//  Purpose   : Pipelined Sklansky parallel-prefix adder/subtractor with
//              valid/ready flow control and a pass-through tag.
//              WIDTH is a power of two; REG_EVERY prefix levels share one
//              pipeline stage. Latency = pfa_lat(WIDTH, REG_EVERY).
//              A single global stall (out_valid && !out_ready) freezes every
//              stage; bubbles are kept in place.
//  Config    : PFA_PIPE_FLAGS_EN adds registered ovf/zero outputs aligned
//              with s.
//  Revision  : 1.0  initial release
// ============================================================================
module pfa_pipe_param
  import pfa_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input wire clk,
  input wire rst,
  pfa_pipe_param_if.slave bus
);

  localparam int c_L    = clog2(WIDTH);
  localparam int c_NS   = pfa_lat(WIDTH, REG_EVERY) - 1;
  localparam int c_LAST = c_NS - 1;

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic w_stall;
  logic w_en;

  assign w_stall      = bus.out_valid && !bus.out_ready;
  assign w_en         = !w_stall;
  assign bus.in_ready = w_en;

  // --------------------------------------------------------------------------
  // Stage 0 logic: operand conditioning and bitwise p/g
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_yy;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;
  logic             w_c0;
  pg_t  [WIDTH-1:0] w_pg0;

  // Invert y for subtract; carry-in folded into bit 0 generate so the prefix
  // network needs no separate carry input.
  always_comb begin
    w_yy    = bus.op_sub ? ~bus.y : bus.y;
    w_c0    = bus.op_sub ? 1'b1 : bus.cin;
    w_p0    = bus.x ^ w_yy;
    w_g0    = bus.x & w_yy;
    w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
    w_pg0   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pg0[i].g = w_g0[i];
      w_pg0[i].p = w_p0[i];
    end
  end

  // --------------------------------------------------------------------------
  // Sklansky prefix network. Level l takes its input from a stage register
  // when l is a multiple of REG_EVERY, otherwise straight from level l-1.
  // --------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < c_L; l++) begin : g_lvl
      pg_t [WIDTH-1:0] w_in;
      pg_t [WIDTH-1:0] w_out;

      if ((l % REG_EVERY) == 0) begin : g_from_reg
        assign w_in = g_stage[l / REG_EVERY].r_pg;
      end else begin : g_from_comb
        assign w_in = g_lvl[l-1].w_out;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_cell
          // Low partner: the group ending just below this bit's 2^l block
          localparam int c_J = ((i >> l) << l) - 1;
          pfa_prefix_cell u_cell (
            .gh (w_in[i].g),
            .ph (w_in[i].p),
            .gl (w_in[c_J].g),
            .pl (w_in[c_J].p),
            .G  (w_out[i].g),
            .P  (w_out[i].p)
          );
        end else begin : g_pass
          assign w_out[i] = w_in[i];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pipeline registers ahead of each group of prefix levels. Stage 0 holds the
  // conditioned operands; stage j holds the result of levels below j*REG_EVERY.
  // The raw bitwise p and c0 travel alongside for the final sum.
  // --------------------------------------------------------------------------
  generate
    for (genvar j = 0; j < c_NS; j++) begin : g_stage
      pg_t  [WIDTH-1:0] w_d_pg;
      logic [WIDTH-1:0] w_d_p;
      logic             w_d_c0;
      logic             w_d_v;
      logic [TAG_W-1:0] w_d_tag;

      pg_t  [WIDTH-1:0] r_pg;
      logic [WIDTH-1:0] r_p;
      logic             r_c0;
      logic             r_v;
      logic [TAG_W-1:0] r_tag;

      if (j == 0) begin : g_first
        assign w_d_pg  = w_pg0;
        assign w_d_p   = w_p0;
        assign w_d_c0  = w_c0;
        assign w_d_v   = bus.in_valid;
        assign w_d_tag = bus.tag_in;
      end else begin : g_mid
        assign w_d_pg  = g_lvl[j*REG_EVERY-1].w_out;
        assign w_d_p   = g_stage[j-1].r_p;
        assign w_d_c0  = g_stage[j-1].r_c0;
        assign w_d_v   = g_stage[j-1].r_v;
        assign w_d_tag = g_stage[j-1].r_tag;
      end

      // Stage register: cleared by reset, frozen during stall
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pg  <= '0;
          r_p   <= '0;
          r_c0  <= 1'b0;
          r_v   <= 1'b0;
          r_tag <= '0;
        end else if (w_en) begin
          r_pg  <= w_d_pg;
          r_p   <= w_d_p;
          r_c0  <= w_d_c0;
          r_v   <= w_d_v;
          r_tag <= w_d_tag;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Final stage: sum from raw p and prefix carries
  // --------------------------------------------------------------------------
  pg_t  [WIDTH-1:0] w_gf;
  logic [WIDTH-1:0] w_pf;
  logic             w_c0f;
  logic [WIDTH-1:0] w_s;
  logic             w_cout;
  logic             w_unused_p;

  assign w_gf   = g_lvl[c_L-1].w_out;
  assign w_pf   = g_stage[c_LAST].r_p;
  assign w_c0f  = g_stage[c_LAST].r_c0;
  assign w_cout = w_gf[WIDTH-1].g;

  // s[i] = p[i] ^ carry into bit i, where carry into bit i is G[i-1]
  always_comb begin
    w_s    = '0;
    w_s[0] = w_pf[0] ^ w_c0f;
    for (int i = 1; i < WIDTH; i++) begin
      w_s[i] = w_pf[i] ^ w_gf[i-1].g;
    end
  end

  // Group propagates of the last level have no consumer
  always_comb begin
    w_unused_p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_unused_p = w_unused_p ^ w_gf[i].p;
    end
  end

  logic             r_out_v;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [TAG_W-1:0] r_tag_out;

  // Output register: result, carry and tag aligned with out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_v   <= 1'b0;
      r_s       <= '0;
      r_cout    <= 1'b0;
      r_tag_out <= '0;
    end else if (w_en) begin
      r_out_v   <= g_stage[c_LAST].r_v;
      r_s       <= w_s;
      r_cout    <= w_cout;
      r_tag_out <= g_stage[c_LAST].r_tag;
    end
  end

  assign bus.out_valid = r_out_v;
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.tag_out   = r_tag_out;

`ifdef PFA_PIPE_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  // Signed overflow = carry into MSB xor carry out; zero detect on the sum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_en) begin
      r_ovf  <= w_gf[WIDTH-2].g ^ w_cout;
      r_zero <= (w_s == '0);
    end
  end

  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
`endif

endmodule : pfa_pipe_param
`default_nettype wire

// File: tb/tb_pfa_pipe_param.sv
`default_nettype none
// ============================================================================
//  Module    : tb_pfa_pipe_param
//  Purpose   : Self-checking bench for pfa_pipe_param. Two instances share
//              the stimulus: WIDTH=32 with REG_EVERY=1 (latency 6) and
//              REG_EVERY=5 (latency 2).
//  Config    : PFA_PIPE_FLAGS_EN enables checks of ovf/zero.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_pfa_pipe_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic        op_sub;
  logic [3:0]  tag_in;
  logic        out_ready;

  always #5 clk = ~clk;

  pfa_pipe_param_if #(.WIDTH(32), .TAG_W(4)) if1 ();
  pfa_pipe_param_if #(.WIDTH(32), .TAG_W(4)) if5 ();

  assign if1.in_valid  = in_valid;
  assign if1.x         = x;
  assign if1.y         = y;
  assign if1.cin       = cin;
  assign if1.op_sub    = op_sub;
  assign if1.tag_in    = tag_in;
  assign if1.out_ready = out_ready;
  assign if5.in_valid  = in_valid;
  assign if5.x         = x;
  assign if5.y         = y;
  assign if5.cin       = cin;
  assign if5.op_sub    = op_sub;
  assign if5.tag_in    = tag_in;
  assign if5.out_ready = out_ready;

  pfa_pipe_param #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  pfa_pipe_param #(.WIDTH(32), .REG_EVERY(5), .TAG_W(4)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic [3:0]  tag;
    logic        ovf;
    logic        zero;
  } exp_t;

  // Reference: plain 33-bit addition; overflow from operand/result signs
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub, input logic [3:0] t);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] sum;
    bb     = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : ci)};
    e.s    = sum[31:0];
    e.cout = sum[32];
    e.tag  = t;
    e.zero = (sum[31:0] == 32'd0);
    e.ovf  = (a[31] == bb[31]) && (sum[31] != a[31]);
    return e;
  endfunction

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    logic [3:0]  tag;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  // Hand-computed directed vectors
  vec_t vecs [10] = '{
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'h5, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
    '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'hA, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
    '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 4'h3, 32'h0000_0002, 1'b1, 1'b0, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h9, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
    '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 4'hC, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
    '{32'h0000_0009, 32'h0000_0002, 1'b1, 1'b1, 4'h6, 32'h0000_0007, 1'b1, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 4'hF, 32'h0000_0000, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
    '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 4'h2, 32'hACF1_3568, 1'b0, 1'b0, 1'b0},
    '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'h4, 32'h0000_0000, 1'b1, 1'b0, 1'b1}
  };

  task automatic check_vec(input string nm, input int v, input logic [31:0] s,
                           input logic co, input logic [3:0] t, input logic ov, input logic z);
    chk({"s_", nm}, 64'(s), 64'(vecs[v].s));
    chk({"cout_", nm}, 64'(co), 64'(vecs[v].cout));
    chk({"tag_", nm}, 64'(t), 64'(vecs[v].tag));
`ifdef PFA_PIPE_FLAGS_EN
    chk({"ovf_", nm}, 64'(ov), 64'(vecs[v].ovf));
    chk({"zero_", nm}, 64'(z), 64'(vecs[v].zero));
`endif
  endtask

  // ---------------------------------------------------------------- scoreboard
  exp_t        q0[$];
  exp_t        q1[$];
  bit          sb_en = 1'b0;
  int          cyc = 0;
  int          n_out [2];
  int          n_acc [2];
  int          first_c [2];
  int          last_c [2];
  logic        prev_stall [2];
  logic [31:0] prev_s [2];
  logic [3:0]  prev_tag [2];
  logic        prev_cout [2];

  task automatic mon(input int d, input logic ov, input logic ir, input logic [31:0] s,
                     input logic co, input logic [3:0] t, input logic fo, input logic fz);
    exp_t e;
    logic stall;
    int   qs;
    stall = ov && !out_ready;
    chk("in_ready", 64'(ir), 64'(!stall));
    if (prev_stall[d]) begin
      chk("hold_valid", 64'(ov), 64'(1));
      chk("hold_s", 64'(s), 64'(prev_s[d]));
      chk("hold_tag", 64'(t), 64'(prev_tag[d]));
      chk("hold_cout", 64'(co), 64'(prev_cout[d]));
    end
    if (in_valid && ir) begin
      e = model(x, y, cin, op_sub, tag_in);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      n_acc[d]++;
    end
    if (ov && out_ready) begin
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        chk("spurious_result", 64'(1), 64'(0));
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("sb_s", 64'(s), 64'(e.s));
        chk("sb_cout", 64'(co), 64'(e.cout));
        chk("sb_tag", 64'(t), 64'(e.tag));
`ifdef PFA_PIPE_FLAGS_EN
        chk("sb_ovf", 64'(fo), 64'(e.ovf));
        chk("sb_zero", 64'(fz), 64'(e.zero));
`endif
        n_out[d]++;
        if (n_out[d] == 1) first_c[d] = cyc;
        last_c[d] = cyc;
      end
    end
    prev_stall[d] = stall;
    prev_s[d]     = s;
    prev_tag[d]   = t;
    prev_cout[d]  = co;
  endtask

  // Monitor samples at the falling edge, half a cycle from the active edge
  always @(negedge clk) begin
    if (sb_en) begin
      cyc++;
`ifdef PFA_PIPE_FLAGS_EN
      mon(0, if1.out_valid, if1.in_ready, if1.s, if1.cout, if1.tag_out, if1.ovf, if1.zero);
      mon(1, if5.out_valid, if5.in_ready, if5.s, if5.cout, if5.tag_out, if5.ovf, if5.zero);
`else
      mon(0, if1.out_valid, if1.in_ready, if1.s, if1.cout, if1.tag_out, 1'b0, 1'b0);
      mon(1, if5.out_valid, if5.in_ready, if5.s, if5.cout, if5.tag_out, 1'b0, 1'b0);
`endif
    end
  end

  task automatic rand_op();
    x      = $urandom;
    y      = $urandom;
    cin    = 1'($urandom_range(0, 1));
    op_sub = 1'($urandom_range(0, 1));
    tag_in = 4'($urandom_range(0, 15));
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      n_out[d]      = 0;
      n_acc[d]      = 0;
      first_c[d]    = 0;
      last_c[d]     = 0;
      prev_stall[d] = 1'b0;
    end
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    bit seen1;
    bit seen5;
    rst       = 1'b1;
    in_valid  = 1'b1;
    x         = 32'hFFFF_FFFF;
    y         = 32'h1;
    cin       = 1'b1;
    op_sub    = 1'b0;
    tag_in    = 4'h7;
    out_ready = 1'b1;
    clear_counts();

    // Reset held three cycles with in_valid asserted
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_valid_r1", 64'(if1.out_valid), 64'(0));
      chk("rst_s_r1", 64'(if1.s), 64'(0));
      chk("rst_cout_r1", 64'(if1.cout), 64'(0));
      chk("rst_tag_r1", 64'(if1.tag_out), 64'(0));
      chk("rst_valid_r5", 64'(if5.out_valid), 64'(0));
      chk("rst_s_r5", 64'(if5.s), 64'(0));
`ifdef PFA_PIPE_FLAGS_EN
      chk("rst_ovf_r1", 64'(if1.ovf), 64'(0));
      chk("rst_zero_r1", 64'(if1.zero), 64'(0));
`endif
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("postrst_valid_r1", 64'(if1.out_valid), 64'(0));
    chk("postrst_valid_r5", 64'(if5.out_valid), 64'(0));
    chk("postrst_ready", 64'(if1.in_ready), 64'(1));

    // Directed vectors: latency, result, carry, tag and flags
    for (int v = 0; v < 10; v++) begin
      in_valid = 1'b1;
      x        = vecs[v].x;
      y        = vecs[v].y;
      cin      = vecs[v].cin;
      op_sub   = vecs[v].sub;
      tag_in   = vecs[v].tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen1    = 1'b0;
      seen5    = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (if1.out_valid && !seen1) begin
          seen1 = 1'b1;
          chk("lat_r1", 64'(k), 64'(6));
`ifdef PFA_PIPE_FLAGS_EN
          check_vec("r1", v, if1.s, if1.cout, if1.tag_out, if1.ovf, if1.zero);
`else
          check_vec("r1", v, if1.s, if1.cout, if1.tag_out, 1'b0, 1'b0);
`endif
        end
        if (if5.out_valid && !seen5) begin
          seen5 = 1'b1;
          chk("lat_r5", 64'(k), 64'(2));
`ifdef PFA_PIPE_FLAGS_EN
          check_vec("r5", v, if5.s, if5.cout, if5.tag_out, if5.ovf, if5.zero);
`else
          check_vec("r5", v, if5.s, if5.cout, if5.tag_out, 1'b0, 1'b0);
`endif
        end
      end
      if (!seen1) chk("timeout_r1", 64'(0), 64'(1));
      if (!seen5) chk("timeout_r5", 64'(0), 64'(1));
      @(posedge clk); #1;
    end

    // Reset with an operation in flight discards it
    in_valid = 1'b1;
    x        = 32'h3;
    y        = 32'h4;
    op_sub   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    seen1 = 1'b0;
    seen5 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if1.out_valid) seen1 = 1'b1;
      if (if5.out_valid) seen5 = 1'b1;
    end
    chk("flush_r1", 64'(seen1), 64'(0));
    chk("flush_r5", 64'(seen5), 64'(0));
    @(posedge clk); #1;

    // Back-to-back: 100 ops, consumer always ready
    clear_counts();
    sb_en     = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      in_valid = 1'b1;
      rand_op();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_count_r1", 64'(n_out[0]), 64'(100));
    chk("b2b_count_r5", 64'(n_out[1]), 64'(100));
    chk("b2b_span_r1", 64'(last_c[0] - first_c[0]), 64'(99));
    chk("b2b_span_r5", 64'(last_c[1] - first_c[1]), 64'(99));
    chk("b2b_empty_r1", 64'(q0.size()), 64'(0));
    chk("b2b_empty_r5", 64'(q1.size()), 64'(0));

    // Backpressure: consumer stalls roughly 30% of cycles
    clear_counts();
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 9) >= 3);
      rand_op();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("bp_count_r1", 64'(n_out[0]), 64'(n_acc[0]));
    chk("bp_count_r5", 64'(n_out[1]), 64'(n_acc[1]));
    chk("bp_empty_r1", 64'(q0.size()), 64'(0));
    chk("bp_empty_r5", 64'(q1.size()), 64'(0));
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pfa_pipe_param
`default_nettype wire
